// File: rtl/traffic_pkg.sv
// Purpose: shared types and constants for the intersection scheduler slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package traffic_pkg;

  // Width of the phase countdown; durations are 1..63 pulses.
  localparam int CNT_W = 6;

  // Lamp encodings, bit order {red, yellow, green}.
  localparam logic [2:0] LED_RED    = 3'b100;
  localparam logic [2:0] LED_YELLOW = 3'b010;
  localparam logic [2:0] LED_GREEN  = 3'b001;

  typedef enum logic [2:0] {
    HW_GREEN    = 3'd0,
    HW_YELLOW   = 3'd1,
    ALL_RED_IN  = 3'd2,
    CR_GREEN    = 3'd3,
    CR_YELLOW   = 3'd4,
    PED_WALK    = 3'd5,
    ALL_RED_OUT = 3'd6
  } phase_e;

  // Which requester was served most recently; used to break ties.
  typedef enum logic {
    SERVED_CR  = 1'b0,
    SERVED_PED = 1'b1
  } served_e;

endpackage

// File: rtl/phase_timer.sv
// Purpose: loadable pulse down-counter holding the remaining pulses of a phase.
// Latency: load/decrement visible one clk after the request; phase_end is combinational.
// Backpressure: none; every pulse is consumed in the cycle it is presented.
// Ports: clk, rst (sync, active-high), load + load_value (phase entry),
//        pulse (1 s tick), sec_count (remaining pulses), phase_end (pulse && sec_count==1).
module phase_timer
  import traffic_pkg::*;
#(
  parameter logic [CNT_W-1:0] RESET_VALUE = 6'd10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             pulse,
  output logic [CNT_W-1:0] sec_count,
  output logic             phase_end
);

  assign phase_end = pulse && (sec_count == CNT_W'(1));

  // Load wins over the pulse: the pulse that ends a phase is the same one
  // that causes the next phase's value to be loaded. At zero the count
  // holds, which is how an idle highway green parks.
  always_ff @(posedge clk) begin
    if (rst) begin
      sec_count <= RESET_VALUE;
    end else if (load) begin
      sec_count <= load_value;
    end else if (pulse && (sec_count != '0)) begin
      sec_count <= sec_count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/intersection_scheduler.sv
// Purpose: highway/country-road phase scheduler with optional pedestrian phase (macro TRAFFIC_PED_EN).
// Latency: lamps and sec_count change on the same clk edge as the phase state.
// Backpressure: none; sensor is a level, ped_req is latched until served.
// Ports: clk, rst (sync, active-high), pulse (1 s tick), sensor (car waiting),
//        ped_req/walk (only with TRAFFIC_PED_EN), highway_led/countryroad_led
//        {red,yellow,green}, sec_count (remaining pulses in phase).
module intersection_scheduler
  import traffic_pkg::*;
#(
  parameter logic [CNT_W-1:0] T_HW_GREEN = 6'd10,
  parameter logic [CNT_W-1:0] T_YELLOW   = 6'd3,
  parameter logic [CNT_W-1:0] T_ALL_RED  = 6'd1,
  parameter logic [CNT_W-1:0] T_CR_GREEN = 6'd5,
  parameter logic [CNT_W-1:0] T_WALK     = 6'd6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse,
  input  logic             sensor,
`ifdef TRAFFIC_PED_EN
  input  logic             ped_req,
  output logic             walk,
`endif
  output logic [2:0]       highway_led,
  output logic [2:0]       countryroad_led,
  output logic [CNT_W-1:0] sec_count
);

  phase_e  state, state_next;
  logic    phase_end;
  logic    phase_load;
  logic    serve_ped;
  served_e last_served;
  logic    ped_pending;
  logic    any_pending;
  logic    grant_ped;
  logic [2:0] hw_led_d, cr_led_d;

  function automatic logic [CNT_W-1:0] phase_len(input phase_e s);
    case (s)
      HW_GREEN:    phase_len = T_HW_GREEN;
      HW_YELLOW:   phase_len = T_YELLOW;
      CR_YELLOW:   phase_len = T_YELLOW;
      CR_GREEN:    phase_len = T_CR_GREEN;
      PED_WALK:    phase_len = T_WALK;
      default:     phase_len = T_ALL_RED;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Phase countdown: reloaded whenever the state changes.
  // ---------------------------------------------------------------------------
  assign phase_load = (state_next != state);

  phase_timer #(
    .RESET_VALUE (T_HW_GREEN)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (phase_load),
    .load_value (phase_len(state_next)),
    .pulse      (pulse),
    .sec_count  (sec_count),
    .phase_end  (phase_end)
  );

  // ---------------------------------------------------------------------------
  // Request qualifiers and arbitration.
  // ---------------------------------------------------------------------------
`ifdef TRAFFIC_PED_EN
  logic ped_absorb;
  logic walk_d;

  // A press is meaningless while walk is already granted or showing.
  assign ped_absorb = (state == PED_WALK) ||
                      (serve_ped && ((state == HW_YELLOW) || (state == ALL_RED_IN)));

  always_ff @(posedge clk) begin
    if (rst) begin
      ped_pending <= 1'b0;
    end else if ((state_next == PED_WALK) && (state != PED_WALK)) begin
      ped_pending <= 1'b0;
    end else if (ped_req && !ped_absorb) begin
      ped_pending <= 1'b1;
    end
  end
`else
  assign ped_pending = 1'b0;
`endif

  assign any_pending = sensor || ped_pending;

  // Only the registered latch takes part, so a press arriving on the
  // departure edge waits for the next arbitration. On a tie the side not
  // served last wins.
  assign grant_ped = ped_pending && (!sensor || (last_served == SERVED_CR));

  // ---------------------------------------------------------------------------
  // FSM: state register (also registers lamps and arbitration results).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= HW_GREEN;
      serve_ped       <= 1'b0;
      last_served     <= SERVED_PED;
      highway_led     <= LED_GREEN;
      countryroad_led <= LED_RED;
`ifdef TRAFFIC_PED_EN
      walk            <= 1'b0;
`endif
    end else begin
      state           <= state_next;
      highway_led     <= hw_led_d;
      countryroad_led <= cr_led_d;
`ifdef TRAFFIC_PED_EN
      walk            <= walk_d;
`endif
      if ((state == HW_GREEN) && (state_next == HW_YELLOW)) begin
        serve_ped <= grant_ped;
      end
      if ((state_next == CR_GREEN) && (state != CR_GREEN)) begin
        last_served <= SERVED_CR;
      end else if ((state_next == PED_WALK) && (state != PED_WALK)) begin
        last_served <= SERVED_PED;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      // Leave once the minimum green has elapsed (ending pulse, or already
      // parked at zero) and someone is waiting.
      HW_GREEN:    if ((phase_end || (sec_count == '0)) && any_pending) state_next = HW_YELLOW;
      HW_YELLOW:   if (phase_end) state_next = ALL_RED_IN;
      ALL_RED_IN:  if (phase_end) state_next = serve_ped ? PED_WALK : CR_GREEN;
      CR_GREEN:    if (phase_end) state_next = CR_YELLOW;
      CR_YELLOW:   if (phase_end) state_next = ALL_RED_OUT;
      PED_WALK:    if (phase_end) state_next = ALL_RED_OUT;
      ALL_RED_OUT: if (phase_end) state_next = HW_GREEN;
      default:     state_next = HW_GREEN;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode of the next state, registered above so lamps switch
  // on the same edge as the state.
  // ---------------------------------------------------------------------------
  always_comb begin
    hw_led_d = LED_RED;
    cr_led_d = LED_RED;
`ifdef TRAFFIC_PED_EN
    walk_d   = 1'b0;
`endif
    case (state_next)
      HW_GREEN:  hw_led_d = LED_GREEN;
      HW_YELLOW: hw_led_d = LED_YELLOW;
      CR_GREEN:  cr_led_d = LED_GREEN;
      CR_YELLOW: cr_led_d = LED_YELLOW;
`ifdef TRAFFIC_PED_EN
      PED_WALK:  walk_d   = 1'b1;
`endif
      default: begin
        hw_led_d = LED_RED;
        cr_led_d = LED_RED;
      end
    endcase
  end

endmodule
